sd_block_port: RTL
==================

SD_BLOCK_PORT -- requirements
Module: sd_block_port

Interface
REQ-001 Parameter BLOCK_WORDS, default 256, words per disk block (one RK05 sector).
REQ-002 Parameter FIFO_WORDS, default 512, depth of each data FIFO (two blocks).
REQ-003 clk  in  1  20 MHz system clock; reset is asynchronous and active-high, port reset  in  1.
REQ-004 sd_dev_sel  in  3  drive select; sd_lba  in  13  linear block address; both sampled with the command.
REQ-005 sd_read / sd_write  in  1  one-cycle command pulses from the controller.
REQ-006 sd_ready  out  1  high when idle and able to accept a command.
REQ-007 sd_write_data  in  16; sd_write_enable  in  1; sd_write_full  out  1  write-FIFO push port.
REQ-008 sd_read_data  out  16; sd_read_enable  in  1; sd_read_empty  out  1  read-FIFO pop port, first-word fall-through.
REQ-009 sd_loaded / sd_write_protect  in  8  per-drive status, indexed by drive number.
REQ-010 sd_error  out  1  one-cycle pulse when a command completes in error.
REQ-011 med_req  out  1; med_wr  out  1; med_dev  out  3; med_lba  out  13; med_ack  in  1  media command handshake.
REQ-012 med_wdata  out  16; med_wstrobe  in  1  media consumes the write-FIFO head word.
REQ-013 med_rdata  in  16; med_rstrobe  in  1  media delivers one word.
REQ-014 med_done  in  1; med_err  in  1  block finished; error qualifier valid with med_done.

Function
REQ-015 The FSM SHALL have states IDLE, WR_FILL, WR_CMD, WR_XFER, RD_WAIT, RD_CMD, RD_XFER, DRAIN and FILLZ.
REQ-016 In IDLE, sd_ready=1; on sd_write, go to WR_FILL, else on sd_read go to RD_WAIT; sd_write wins if both pulse in the same cycle.
REQ-017 Dev and lba SHALL latch on the accepting edge; sd_ready SHALL be 0 on the following cycle and stay 0 until return to IDLE.
REQ-018 WR_FILL waits until write-FIFO count >= BLOCK_WORDS; an unloaded drive goes to DRAIN, a loaded drive goes to WR_CMD.
REQ-019 WR_CMD/RD_CMD hold med_req=1 with med_wr, dev and lba stable until med_ack, then enter the XFER state.
REQ-020 WR_XFER pops one word per med_wstrobe; med_wdata = FIFO head, combinational.
REQ-021 RD_WAIT waits until read-FIFO free space >= BLOCK_WORDS; an unloaded drive goes to FILLZ, a loaded drive goes to RD_CMD.
REQ-022 RD_XFER pushes med_rdata per med_rstrobe; pushes beyond BLOCK_WORDS in one block SHALL be discarded.
REQ-023 med_done in an XFER state returns to IDLE; with med_err=1, sd_error pulses that cycle.
REQ-024 DRAIN pops BLOCK_WORDS words at one per cycle; FILLZ pushes BLOCK_WORDS zeros at one per cycle; both then pulse sd_error and return to IDLE.
REQ-025 The 8-bit word counter SHALL clear on command acceptance and wrap at BLOCK_WORDS.
REQ-026 sd_write_full = (count == FIFO_WORDS); a push while full SHALL be dropped.
REQ-027 sd_read_empty = (count == 0); a pop while empty SHALL be ignored and sd_read_data holds.
REQ-028 A simultaneous push and pop on one FIFO SHALL leave its count unchanged.
REQ-029 Controller-side FIFO ports SHALL operate in every state, including during media transfer.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, empty both FIFOs and clear the counters.
REQ-031 While reset is asserted: sd_ready=1, sd_read_empty=1, sd_write_full=0, sd_error=0, med_req=0, med_wr=0; data outputs are 0.
REQ-032 Reset mid-transfer SHALL abandon the block without a further med_req; subsequent media strobes SHALL be ignored.

Configuration
REQ-033 Macro SD_WRITE_PROTECT_EN: when defined, in WR_FILL a loaded drive with sd_write_protect[dev]=1 SHALL go to DRAIN with no media access, then pulse sd_error.
REQ-034 Without SD_WRITE_PROTECT_EN, sd_write_protect SHALL be ignored and protected drives written normally.

Verification
REQ-035 Write sd_lba=13'd100, dev 0: push 256 words 0..255, pulse sd_write -> med_req, med_wr=1, med_lba=100; media strobes receive 0..255; sd_ready=1 after med_done.
REQ-036 Read lba 5: media supplies 256 words 0xA000+i -> sd_read_empty falls; 256 pops return 0xA000..0xA0FF, then sd_read_empty=1.
REQ-037 Push 513 words -> sd_write_full=1 at 512; the 513th word is absent from media data.
REQ-038 Read on drive 3 with sd_loaded[3]=0 -> no med_req; 256 zero words appear; one sd_error pulse.
REQ-039 SD_WRITE_PROTECT_EN defined, sd_write_protect[1]=1, write to dev 1 -> FIFO drains to empty, no med_req, sd_error pulse; without the macro -> normal media write.
REQ-040 Reset asserted mid-RD_XFER after 100 words -> read FIFO empty, IDLE, sd_ready=1; later med_rstrobe pushes nothing.

Source files
------------

// File: rtl/sd_block_port.sv
`default_nettype none
// ============================================================================
// Module      : sd_block_port (with helper sd_block_port_fifo)
// Description : Block-oriented disk port. It buffers controller write data
//               and media read data in two first-word fall-through FIFOs and
//               sequences one block per command through a media handshake.
//               Drives that are not loaded are serviced locally: writes are
//               drained, and reads return a block of zeros. Both cases end
//               with an error pulse.
// Options     : define SD_WRITE_PROTECT_EN to make writes to protected drives
//               drain locally with an error instead of reaching the media.
// Revision    : 1.0 - initial release
// ============================================================================

module sd_block_port_fifo #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;
    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign w_full    = (count_q == CNT_FULL);
    assign w_empty   = (count_q == '0);
    assign w_push_ok = push_i && !w_full;
    assign w_pop_ok  = pop_i && !w_empty;
    // An empty FIFO presents zero so the head output is defined after reset.
    assign data_o    = w_empty ? '0 : mem_q[rptr_q];
    assign count_o   = count_q;

    // Storage array; written only when a push is accepted.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointers and occupancy; a push and pop together leave the count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push_ok) begin
                wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + AW'(1);
            end
            if (w_pop_ok) begin
                rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end
endmodule

module sd_block_port #(
    parameter int BLOCK_WORDS = 256,
    parameter int FIFO_WORDS  = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  sd_dev_sel,
    input  logic [12:0] sd_lba,
    input  logic        sd_read,
    input  logic        sd_write,
    output logic        sd_ready,
    input  logic [15:0] sd_write_data,
    input  logic        sd_write_enable,
    output logic        sd_write_full,
    output logic [15:0] sd_read_data,
    input  logic        sd_read_enable,
    output logic        sd_read_empty,
    input  logic [7:0]  sd_loaded,
    input  logic [7:0]  sd_write_protect,
    output logic        sd_error,
    output logic        med_req,
    output logic        med_wr,
    output logic [2:0]  med_dev,
    output logic [12:0] med_lba,
    input  logic        med_ack,
    output logic [15:0] med_wdata,
    input  logic        med_wstrobe,
    input  logic [15:0] med_rdata,
    input  logic        med_rstrobe,
    input  logic        med_done,
    input  logic        med_err
);
    localparam int FCW  = $clog2(FIFO_WORDS + 1);
    localparam int CNTW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [FCW-1:0]  FIFO_FULL_CNT = FCW'(FIFO_WORDS);
    localparam logic [FCW-1:0]  BLK_CNT       = FCW'(BLOCK_WORDS);
    localparam logic [CNTW-1:0] CNT_LAST      = CNTW'(BLOCK_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WR_FILL = 4'd1,
        WR_CMD  = 4'd2,
        WR_XFER = 4'd3,
        RD_WAIT = 4'd4,
        RD_CMD  = 4'd5,
        RD_XFER = 4'd6,
        DRAIN   = 4'd7,
        FILLZ   = 4'd8
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      dev_q, dev_d;
    logic [12:0]     lba_q, lba_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            blk_full_q, blk_full_d;

    logic [FCW-1:0]  w_wf_count;
    logic [FCW-1:0]  w_rf_count;
    logic            w_wf_pop;
    logic            w_rf_push;
    logic [15:0]     w_rf_din;
    logic            w_err;
    logic            w_wp_hit;
    logic            w_wf_ready;
    logic            w_rf_space_ok;
    logic [CNTW-1:0] w_cnt_inc;

    // Controller pushes write data in every state; media/DRAIN pop it.
    sd_block_port_fifo #(.DEPTH(FIFO_WORDS), .DATA_W(16)) u_wr_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (sd_write_enable),
        .data_i  (sd_write_data),
        .pop_i   (w_wf_pop),
        .data_o  (med_wdata),
        .count_o (w_wf_count)
    );

    // Media/FILLZ push read data; the controller pops it in every state.
    sd_block_port_fifo #(.DEPTH(FIFO_WORDS), .DATA_W(16)) u_rd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_rf_push),
        .data_i  (w_rf_din),
        .pop_i   (sd_read_enable),
        .data_o  (sd_read_data),
        .count_o (w_rf_count)
    );

`ifdef SD_WRITE_PROTECT_EN
    assign w_wp_hit = sd_write_protect[dev_q];
`else
    // Protection is not honoured in this build; protected drives write normally.
    assign w_wp_hit = sd_write_protect[dev_q] & 1'b0;
`endif

    assign w_wf_ready    = (w_wf_count >= BLK_CNT);
    assign w_rf_space_ok = ((FIFO_FULL_CNT - w_rf_count) >= BLK_CNT);
    assign w_cnt_inc     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNTW'(1);

    assign sd_ready      = (state_q == IDLE);
    assign sd_write_full = (w_wf_count == FIFO_FULL_CNT);
    assign sd_read_empty = (w_rf_count == '0);
    assign sd_error      = w_err;
    assign med_req       = (state_q == WR_CMD) || (state_q == RD_CMD);
    assign med_wr        = (state_q == WR_CMD) || (state_q == WR_XFER);
    assign med_dev       = dev_q;
    assign med_lba       = lba_q;

    // Command sequencing: next state, latched command, word counting, FIFO strobes.
    always_comb begin
        state_d    = state_q;
        dev_d      = dev_q;
        lba_d      = lba_q;
        cnt_d      = cnt_q;
        blk_full_d = blk_full_q;
        w_err      = 1'b0;
        w_wf_pop   = 1'b0;
        w_rf_push  = 1'b0;
        w_rf_din   = med_rdata;
        case (state_q)
            IDLE: begin
                if (sd_write || sd_read) begin
                    state_d    = sd_write ? WR_FILL : RD_WAIT;
                    dev_d      = sd_dev_sel;
                    lba_d      = sd_lba;
                    cnt_d      = '0;
                    blk_full_d = 1'b0;
                end
            end
            WR_FILL: begin
                if (w_wf_ready) begin
                    state_d = (!sd_loaded[dev_q] || w_wp_hit) ? DRAIN : WR_CMD;
                end
            end
            WR_CMD: begin
                if (med_ack) begin
                    state_d = WR_XFER;
                end
            end
            WR_XFER: begin
                if (med_wstrobe) begin
                    w_wf_pop = 1'b1;
                    cnt_d    = w_cnt_inc;
                end
                if (med_done) begin
                    state_d = IDLE;
                    w_err   = med_err;
                end
            end
            RD_WAIT: begin
                if (w_rf_space_ok) begin
                    state_d = sd_loaded[dev_q] ? RD_CMD : FILLZ;
                end
            end
            RD_CMD: begin
                if (med_ack) begin
                    state_d = RD_XFER;
                end
            end
            RD_XFER: begin
                // Words past the end of the block are discarded.
                if (med_rstrobe && !blk_full_q) begin
                    w_rf_push = 1'b1;
                    cnt_d     = w_cnt_inc;
                    if (cnt_q == CNT_LAST) begin
                        blk_full_d = 1'b1;
                    end
                end
                if (med_done) begin
                    state_d = IDLE;
                    w_err   = med_err;
                end
            end
            DRAIN: begin
                w_wf_pop = 1'b1;
                cnt_d    = w_cnt_inc;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    w_err   = 1'b1;
                end
            end
            FILLZ: begin
                w_rf_push = 1'b1;
                w_rf_din  = 16'h0000;
                cnt_d     = w_cnt_inc;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    w_err   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command registers; reset abandons any block in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dev_q      <= '0;
            lba_q      <= '0;
            cnt_q      <= '0;
            blk_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dev_q      <= dev_d;
            lba_q      <= lba_d;
            cnt_q      <= cnt_d;
            blk_full_q <= blk_full_d;
        end
    end
endmodule
`default_nettype wire
